// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives the four {i1,i0} vectors into a 2-input gate,
// samples its output after a settle time and scores it against a truth table.
module gate_truth_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    output logic       dut_i0,
    output logic       dut_i1,
    input  logic       dut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [2:0]    r_op_q;
    logic [2:0]    w_op_q_nx;
    logic [1:0]    r_vec;
    logic [1:0]    w_vec_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_busy;
    logic          w_busy_nx;
    logic          r_done;
    logic          w_done_nx;
    logic          r_pass;
    logic          w_pass_nx;
    logic [3:0]    r_fail;
    logic [3:0]    w_fail_nx;
    logic [3:0]    w_fail_smp;
    logic [2:0]    r_err;
    logic [2:0]    w_err_nx;
    logic          w_exp;
    logic          w_mis;

    // Reference truth table; NOT looks only at i0 and ignores i1.
    function automatic logic f_expect(input logic [2:0] f_op,
                                      input logic [1:0] f_v);
        logic l_r;
        l_r = 1'b0;
        case (f_op)
            3'd0:    l_r = ~f_v[0];
            3'd1:    l_r = f_v[0] & f_v[1];
            3'd2:    l_r = f_v[0] | f_v[1];
            3'd3:    l_r = f_v[0] ^ f_v[1];
            3'd4:    l_r = ~(f_v[0] & f_v[1]);
            default: l_r = 1'b0;
        endcase
        return l_r;
    endfunction

    // Compare the settled gate output against the expected value.
    always_comb begin
        w_exp      = f_expect(r_op_q, r_vec);
        w_mis      = (dut_o != w_exp);
        w_fail_smp = r_fail | ({3'b000, w_mis} << r_vec);
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_op_q_nx  = r_op_q;
        w_vec_nx   = r_vec;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_pass_nx  = r_pass;
        w_fail_nx  = r_fail;
        w_err_nx   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_vec_nx  = 2'd0;
                    w_busy_nx = 1'b1;
                    w_pass_nx = 1'b0;
                    w_err_nx  = 3'd0;
                    if (op <= 3'd4) begin
                        w_op_q_nx  = op;
                        w_fail_nx  = 4'b0000;
                        w_cnt_nx   = CNT_RELOAD;
                        w_state_nx = S_WAIT;
                    end else begin
                        // Illegal op: no sweep, flag every vector.
                        w_fail_nx  = 4'b1111;
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_SAMPLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_SAMPLE: begin
                w_fail_nx = w_fail_smp;
                w_err_nx  = r_err + {2'b00, w_mis};
                if (r_vec == 2'd3) begin
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_pass_nx  = (w_fail_smp == 4'b0000);
                    w_state_nx = S_DONE;
                end else begin
                    w_vec_nx   = r_vec + 2'd1;
                    w_cnt_nx   = CNT_RELOAD;
                    w_state_nx = S_WAIT;
                end
            end
            S_DONE: begin
                // Illegal-op path arrives with done low and raises it here.
                if (!r_done) begin
                    w_done_nx = 1'b1;
                    w_busy_nx = 1'b0;
                    w_pass_nx = (r_fail == 4'b0000);
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op_q  <= 3'd0;
            r_vec   <= 2'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 4'b0000;
            r_err   <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_op_q  <= w_op_q_nx;
            r_vec   <= w_vec_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_pass  <= w_pass_nx;
            r_fail  <= w_fail_nx;
            r_err   <= w_err_nx;
        end
    end

    assign dut_i0    = r_vec[0];
    assign dut_i1    = r_vec[1];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_vec  = r_fail;
    assign err_count = r_err;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: table of sweeps against modelled gates, scoreboard
// queue of expected results, plus hand sequences for start-hold and reset.
module tb_gate_truth_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic       dut_i0;
    logic       dut_i1;
    logic       dut_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_vec;
    logic [2:0] err_count;

    // gate model: 0 AND 1 OR 2 stuck1 3 stuck0 4 XOR 5 NAND 6 NOT
    logic [2:0] gmode;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] op;
        logic [2:0] gmode;
        logic       legal;
        logic [3:0] fail;
        logic [2:0] err;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t tbl[10];
    vec_t sbq[$];

    gate_truth_checker #(.SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .dut_i0    (dut_i0),
        .dut_i1    (dut_i1),
        .dut_o     (dut_o),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_vec  (fail_vec),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_o = 1'b0;
        case (gmode)
            3'd0: dut_o = dut_i0 & dut_i1;
            3'd1: dut_o = dut_i0 | dut_i1;
            3'd2: dut_o = 1'b1;
            3'd3: dut_o = 1'b0;
            3'd4: dut_o = dut_i0 ^ dut_i1;
            3'd5: dut_o = ~(dut_i0 & dut_i1);
            3'd6: dut_o = ~dut_i0;
            default: dut_o = 1'b0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        vec_t e;
        int   n;
        gmode = t.gmode;
        @(negedge clk);
        op    = t.op;
        start = 1'b1;
        sbq.push_back(t);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (t.legal && (k % 3) == 2 && k <= 11)
                chk("vec_order", int'({dut_i1, dut_i0}), (k - 2) / 3);
            if (done) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            chk("done_timeout", 0, 1);
            void'(sbq.pop_front());
        end else if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("latency", n, e.lat);
            chk("fail_vec", int'(fail_vec), int'(e.fail));
            chk("err_count", int'(err_count), int'(e.err));
            chk("pass", int'(pass), int'(e.pass));
            chk("busy_at_done", int'(busy), 0);
            chk("last_vec", int'({dut_i1, dut_i0}), e.legal ? 3 : 0);
        end
        @(posedge clk);
        #1;
        chk("done_pulse", int'(done), 0);
    endtask

    initial begin
        int dn;
        int dk;
        logic [3:0] f5;
        logic [2:0] e5;

        //            op    gmode legal fail     err  pass lat
        tbl[0] = '{3'd1, 3'd0, 1'b1, 4'b0000, 3'd0, 1'b1, 12};
        tbl[1] = '{3'd1, 3'd1, 1'b1, 4'b0110, 3'd2, 1'b0, 12};
        tbl[2] = '{3'd4, 3'd2, 1'b1, 4'b1000, 3'd1, 1'b0, 12};
        tbl[3] = '{3'd3, 3'd3, 1'b1, 4'b0110, 3'd2, 1'b0, 12};
        tbl[4] = '{3'd6, 3'd0, 1'b0, 4'b1111, 3'd0, 1'b0, 1};
        tbl[5] = '{3'd0, 3'd6, 1'b1, 4'b0000, 3'd0, 1'b1, 12};
        tbl[6] = '{3'd0, 3'd0, 1'b1, 4'b1101, 3'd3, 1'b0, 12};
        tbl[7] = '{3'd2, 3'd4, 1'b1, 4'b1000, 3'd1, 1'b0, 12};
        tbl[8] = '{3'd5, 3'd1, 1'b0, 4'b1111, 3'd0, 1'b0, 1};
        tbl[9] = '{3'd4, 3'd5, 1'b1, 4'b0000, 3'd0, 1'b1, 12};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        gmode = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            int'({busy, done, pass, fail_vec, err_count, dut_i1, dut_i0}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // start held high, op changes mid-sweep; judged as AND vs OR gate
        gmode = 3'd1;
        @(negedge clk);
        op    = 3'd1;
        start = 1'b1;
        @(posedge clk);
        dn = 0;
        dk = 0;
        f5 = 4'b0000;
        e5 = 3'd0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) op = 3'd2;
            if (done) begin
                dn++;
                dk = k;
                f5 = fail_vec;
                e5 = err_count;
            end
        end
        chk("hold_done_count", dn, 1);
        chk("hold_latency", dk, 12);
        chk("hold_fail_vec", int'(f5), 4'b0110);
        chk("hold_err", int'(e5), 2);
        chk("hold_idle_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("hold_restart_busy", int'(busy), 1);
        start = 1'b0;

        // reset at edge 5 of that second sweep
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_outputs",
            int'({busy, done, pass, fail_vec, err_count, dut_i1, dut_i0}), 0);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("midreset_no_done", dn, 0);
        chk("midreset_idle", int'(busy), 0);

        tbl[0] = '{3'd2, 3'd1, 1'b1, 4'b0000, 3'd0, 1'b1, 12};
        run_vec(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
